// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg
//   Shared types, widths and the round-robin pick function used by the
//   multiplier-sharing arbiter and any other shared-resource controller.
//   Contents:
//     DATA_W       operand / product width
//     MAX_REQ      widest requester vector rr_pick can handle
//     arb_state_t  IDLE -> ISSUE -> WAIT -> RESP controller states
//     rr_pick      one-hot grant of the first set request at or after ptr
package mult_arb_pkg;

  localparam int DATA_W  = 64;
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

  // Walks the candidates from the highest offset down so that the lowest
  // offset from ptr (the highest priority) is the last one written.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [2:0]         ptr,
                                                 input int                 num);
    logic [MAX_REQ-1:0] pick;
    int                 idx;
    pick = '0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (i < num) begin
        idx = int'(ptr) + i;
        if (idx >= num) idx = idx - num;
        if (req[idx[2:0]]) begin
          pick = '0;
          pick[idx[2:0]] = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mult_share_arbiter_if.sv
// mult_share_arbiter_if
//   Bundles the requester handshake and the multiplier start/done bus.
//   Requester side : req, req_mcand, req_mplier (in) / gnt, rsp_valid,
//                    rsp_error, rsp_product (out)
//   Multiplier side: mult_start, mult_mcand, mult_mplier (out) /
//                    mult_product, mult_done (in)
//   modport master : the arbiter
//   modport slave  : the requesters plus the multiplier
interface mult_share_arbiter_if
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_mcand;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_mplier;
  logic [NUM_REQ-1:0]             gnt;
  logic [NUM_REQ-1:0]             rsp_valid;
  logic                           rsp_error;
  logic [DATA_W-1:0]              rsp_product;
  logic                           mult_start;
  logic [DATA_W-1:0]              mult_mcand;
  logic [DATA_W-1:0]              mult_mplier;
  logic [DATA_W-1:0]              mult_product;
  logic                           mult_done;

  modport master (
    input  req, req_mcand, req_mplier, mult_product, mult_done,
    output gnt, rsp_valid, rsp_error, rsp_product,
           mult_start, mult_mcand, mult_mplier
  );

  modport slave (
    output req, req_mcand, req_mplier, mult_product, mult_done,
    input  gnt, rsp_valid, rsp_error, rsp_product,
           mult_start, mult_mcand, mult_mplier
  );

endinterface

// File: rtl/mult_share_arbiter_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin picker, reusable by any shared-resource
//   controller.
//   req     in   NUM_REQ  pending requests
//   ptr     in   IDX_W    highest-priority requester index
//   onehot  out  NUM_REQ  one-hot winner (0 when nothing pending)
//   index   out  IDX_W    binary index of the winner
//   any     out  1        at least one request pending
module rr_arbiter
  import mult_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   index,
  output logic               any
);

  logic [MAX_REQ-1:0] req_ext;
  logic [MAX_REQ-1:0] pick;
  logic [2:0]         ptr_ext;

  always_comb begin
    req_ext = '0;
    req_ext[NUM_REQ-1:0] = req;
    ptr_ext = '0;
    ptr_ext[IDX_W-1:0] = ptr;
    pick   = rr_pick(req_ext, ptr_ext, NUM_REQ);
    onehot = pick[NUM_REQ-1:0];
    any    = |pick;
    index  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (onehot[i]) index = IDX_W'(i);
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//   Shares one iterative 64x64->64 multiplier among NUM_REQ requesters with
//   round-robin arbitration and a single multiply in flight. A watchdog
//   returns an error response if the multiplier never signals done.
//   clock  in   system clock, rising edge
//   reset  in   asynchronous, active-high
//   bus    master modport: req/operands in, gnt/rsp out, multiplier bus
//   busy   out  high in every state except IDLE
//   WAIT_MAX: WAIT cycles allowed after mult_start before timing out.
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int WAIT_MAX = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  mult_share_arbiter_if.master bus,
  output logic                 busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = $clog2(WAIT_MAX + 1);

  arb_state_t         state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   owner;
  logic [WD_W-1:0]    wd_cnt;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req    (bus.req),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .index  (pick_idx),
    .any    (pick_any)
  );

  // The grant has to be visible in the same cycle the operands are sampled,
  // so it is the only combinational output; it is forced low during reset.
  assign bus.gnt = (state == IDLE && !reset) ? pick_onehot : '0;

  // rsp_error doubles as the timeout flag and rsp_product as the product
  // register; both are only non-zero while in RESP.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      owner           <= '0;
      wd_cnt          <= '0;
      busy            <= 1'b0;
      bus.mult_start  <= 1'b0;
      bus.mult_mcand  <= '0;
      bus.mult_mplier <= '0;
      bus.rsp_valid   <= '0;
      bus.rsp_error   <= 1'b0;
      bus.rsp_product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            bus.mult_mcand  <= bus.req_mcand[pick_idx];
            bus.mult_mplier <= bus.req_mplier[pick_idx];
            owner           <= pick_idx;
            bus.mult_start  <= 1'b1;
            busy            <= 1'b1;
            state           <= ISSUE;
          end
        end
        ISSUE: begin
          bus.mult_start <= 1'b0;
          wd_cnt         <= '0;
          state          <= WAIT;
        end
        WAIT: begin
          // Done is checked first so a completion in the timeout cycle wins.
          // Timing out when the incremented count reaches WAIT_MAX gives
          // exactly WAIT_MAX cycles in WAIT.
          if (bus.mult_done) begin
            bus.rsp_product <= bus.mult_product;
            bus.rsp_error   <= 1'b0;
            bus.rsp_valid   <= NUM_REQ'(1) << owner;
            state           <= RESP;
          end else if (wd_cnt == WD_W'(WAIT_MAX - 1)) begin
            bus.rsp_product <= '0;
            bus.rsp_error   <= 1'b1;
            bus.rsp_valid   <= NUM_REQ'(1) << owner;
            state           <= RESP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        RESP: begin
          bus.rsp_valid   <= '0;
          bus.rsp_error   <= 1'b0;
          bus.rsp_product <= '0;
          rr_ptr          <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
          busy            <= 1'b0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter
//   Scoreboard bench for mult_share_arbiter: directed requests push expected
//   grants and responses into queues; a negedge monitor pops and compares.
//   The multiplier is an 8-cycle behavioural model with a hang switch.
module tb_mult_share_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int WAIT_MAX = 255;
  localparam int MULT_LAT = 8;

  logic clock;
  logic reset;
  logic busy;

  mult_share_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  mult_share_arbiter #(.NUM_REQ(NUM_REQ), .WAIT_MAX(WAIT_MAX)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct { int idx; logic [63:0] mcand; logic [63:0] mplier; } gnt_exp_t;
  typedef struct { int idx; logic [63:0] product; logic err; } rsp_exp_t;

  gnt_exp_t gnt_q[$];
  rsp_exp_t rsp_q[$];
  gnt_exp_t g;
  rsp_exp_t r;
  int total = 0;
  int bad   = 0;

  // Multiplier model: product appears a fixed latency after mult_start,
  // unless hang is set; shares the arbiter reset.
  logic        hang;
  logic        stray_done;
  logic        model_done;
  logic [63:0] model_a;
  logic [63:0] model_b;
  int          model_cnt;

  assign bus.mult_done = model_done | stray_done;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      model_cnt        <= 0;
      model_done       <= 1'b0;
      model_a          <= '0;
      model_b          <= '0;
      bus.mult_product <= '0;
    end else begin
      model_done <= 1'b0;
      if (bus.mult_start) begin
        model_a   <= bus.mult_mcand;
        model_b   <= bus.mult_mplier;
        model_cnt <= MULT_LAT;
      end else if (model_cnt != 0) begin
        model_cnt <= model_cnt - 1;
        if (model_cnt == 1 && !hang) begin
          model_done       <= 1'b1;
          bus.mult_product <= model_a * model_b;
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor
  int          cyc = 0;
  int          start_cyc = 0;
  logic        prev_gnt = 1'b0;
  logic        prev_done = 1'b0;
  logic [63:0] cur_mcand = '0;
  logic [63:0] cur_mplier = '0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (!reset) begin
      if (|bus.gnt) begin
        if (gnt_q.size() == 0) begin
          check_output("unexpected_gnt", 64'(bus.gnt), 64'd0);
        end else begin
          g = gnt_q.pop_front();
          check_output("gnt", 64'(bus.gnt), 64'd1 << g.idx);
          cur_mcand  = g.mcand;
          cur_mplier = g.mplier;
        end
      end
      if (bus.mult_start) begin
        check_output("start_after_gnt", 64'(prev_gnt), 64'd1);
        check_output("mult_mcand", bus.mult_mcand, cur_mcand);
        check_output("mult_mplier", bus.mult_mplier, cur_mplier);
        start_cyc = cyc;
      end
      if (|bus.rsp_valid) begin
        if (rsp_q.size() == 0) begin
          check_output("unexpected_rsp", 64'(bus.rsp_valid), 64'd0);
        end else begin
          r = rsp_q.pop_front();
          check_output("rsp_valid", 64'(bus.rsp_valid), 64'd1 << r.idx);
          check_output("rsp_product", bus.rsp_product, r.product);
          check_output("rsp_error", 64'(bus.rsp_error), 64'(r.err));
          if (r.err) check_output("timeout_latency", 64'(cyc - start_cyc), 64'(WAIT_MAX + 1));
          else       check_output("rsp_after_done", 64'(prev_done), 64'd1);
        end
      end else begin
        check_output("quiet_rsp_product", bus.rsp_product, 64'd0);
        check_output("quiet_rsp_error", 64'(bus.rsp_error), 64'd0);
      end
    end
    prev_gnt  = |bus.gnt;
    prev_done = bus.mult_done;
  end

  // Stimulus helpers
  task automatic expect_txn(input int idx, input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] prod, input logic err, input bit with_rsp);
    gnt_exp_t ge;
    rsp_exp_t re;
    bus.req_mcand[idx]  = a;
    bus.req_mplier[idx] = b;
    ge.idx = idx; ge.mcand = a; ge.mplier = b;
    gnt_q.push_back(ge);
    if (with_rsp) begin
      re.idx = idx; re.product = prod; re.err = err;
      rsp_q.push_back(re);
    end
  endtask

  // Holds req until n_rsp responses have been seen, dropping it during the
  // last RESP cycle so no further grant follows.
  task automatic apply_stimulus(input logic [NUM_REQ-1:0] mask, input int n_rsp, input int budget);
    int got;
    got = 0;
    @(posedge clock); #1;
    bus.req = mask;
    for (int c = 0; c < budget && got < n_rsp; c++) begin
      @(posedge clock); #1;
      if (|bus.rsp_valid) begin
        got++;
        if (got == n_rsp) bus.req = '0;
      end
    end
    bus.req = '0;
    check_output("rsp_count", 64'(got), 64'(n_rsp));
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_busy"}, 64'(busy), 64'd0);
    check_output({tag, "_gnt"}, 64'(bus.gnt), 64'd0);
    check_output({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    check_output({tag, "_rsp_error"}, 64'(bus.rsp_error), 64'd0);
    check_output({tag, "_rsp_product"}, bus.rsp_product, 64'd0);
    check_output({tag, "_mult_start"}, 64'(bus.mult_start), 64'd0);
    check_output({tag, "_mult_mcand"}, bus.mult_mcand, 64'd0);
    check_output({tag, "_mult_mplier"}, bus.mult_mplier, 64'd0);
  endtask

  initial begin
    bit found;
    reset          = 1'b1;
    hang           = 1'b0;
    stray_done     = 1'b0;
    bus.req        = '0;
    bus.req_mcand  = '0;
    bus.req_mplier = '0;
    repeat (2) @(posedge clock);
    #1 check_all_zero("reset");
    reset = 1'b0;

    $display("[TB] single request");
    expect_txn(0, 64'd3, 64'd5, 64'd15, 1'b0, 1'b1);
    apply_stimulus(4'b0001, 1, 100);

    $display("[TB] contention");
    do_reset();
    expect_txn(0, 64'd2,     64'd7,     64'd14,      1'b0, 1'b1);
    expect_txn(1, 64'd10,    64'd10,    64'd100,     1'b0, 1'b1);
    expect_txn(2, 64'h100,   64'h100,   64'h10000,   1'b0, 1'b1);
    expect_txn(3, 64'd6,     64'd9,     64'd54,      1'b0, 1'b1);
    expect_txn(0, 64'd2,     64'd7,     64'd14,      1'b0, 1'b1);
    apply_stimulus(4'b1111, 5, 300);

    $display("[TB] wrap and fairness");
    do_reset();
    expect_txn(0, 64'd11,    64'd13,    64'd143,     1'b0, 1'b1);
    expect_txn(3, 64'h1234,  64'h10,    64'h12340,   1'b0, 1'b1);
    expect_txn(0, 64'd11,    64'd13,    64'd143,     1'b0, 1'b1);
    expect_txn(3, 64'h1234,  64'h10,    64'h12340,   1'b0, 1'b1);
    apply_stimulus(4'b1001, 4, 200);

    $display("[TB] timeout");
    hang = 1'b1;
    expect_txn(1, 64'h55, 64'h66, 64'd0, 1'b1, 1'b1);
    apply_stimulus(4'b0010, 1, 400);
    hang = 1'b0;

    $display("[TB] reset during WAIT");
    expect_txn(2, 64'd7, 64'd8, 64'd0, 1'b0, 1'b0);
    @(posedge clock); #1;
    bus.req = 4'b0100;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(posedge clock); #1;
      if (bus.mult_start) found = 1'b1;
    end
    check_output("reset_test_start_seen", 64'(found), 64'd1);
    bus.req = '0;
    repeat (2) @(posedge clock);
    #3;
    check_output("busy_in_wait", 64'(busy), 64'd1);
    reset = 1'b1;
    #1 check_all_zero("async_reset");
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (20) @(posedge clock);
    #1 check_output("busy_after_reset", 64'(busy), 64'd0);
    expect_txn(2, 64'd9, 64'd9, 64'd81, 1'b0, 1'b1);
    apply_stimulus(4'b0100, 1, 100);

    $display("[TB] stray done and max operands");
    @(posedge clock); #1;
    stray_done = 1'b1;
    @(posedge clock); #1;
    stray_done = 1'b0;
    repeat (3) @(posedge clock);
    #1 check_output("stray_done_busy", 64'(busy), 64'd0);
    expect_txn(1, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 1'b1);
    apply_stimulus(4'b0010, 1, 100);
    expect_txn(3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1);
    apply_stimulus(4'b1000, 1, 100);

    repeat (5) @(posedge clock);
    #1;
    check_output("gnt_q_drained", 64'(gnt_q.size()), 64'd0);
    check_output("rsp_q_drained", 64'(rsp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
